// File: rtl/if_fetch_pkg.sv
// Shared bus widths, the nop encoding and the fetch-stage default constants.
package if_fetch_pkg;

  localparam int ADDR_BUS = 32;
  localparam int INST_BUS = 32;
  localparam int DATA_BUS = 32;

  typedef logic [ADDR_BUS-1:0] addr_t;
  typedef logic [INST_BUS-1:0] inst_t;

  // Decode treats an all-zero word as a nop.
  localparam inst_t INST_NOP = '0;

  localparam addr_t RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam addr_t PC_STEP_DEFAULT  = 32'd4;

endpackage

// File: rtl/if_fetch_pc_next_sel.sv
// Next-PC priority mux: a recorded branch beats a live branch, which beats
// the sequential step. Only consulted on the handoff cycle.
module pc_next_sel
  import if_fetch_pkg::*;
#(
  parameter logic [ADDR_BUS-1:0] PC_STEP = PC_STEP_DEFAULT
) (
  input  logic [ADDR_BUS-1:0] pc,
  input  logic                br_pend,
  input  logic [ADDR_BUS-1:0] br_target,
  input  logic                branch_flag,
  input  logic [ADDR_BUS-1:0] branch_addr,
  output logic [ADDR_BUS-1:0] next_pc
);

  // Select the address of the fetch that follows the delay slot.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    next_pc = pc + PC_STEP;  // 32-bit wrap is intentional
    if (br_pend) begin
      next_pc = br_target;
    end else if (branch_flag) begin
      next_pc = branch_addr;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, keeps one ROM request in flight,
// presents the fetched word to decode and applies branch/flush redirects.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [ADDR_BUS-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [ADDR_BUS-1:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic [ADDR_BUS-1:0] flush_pc,
  input  logic                branch_flag,
  input  logic [ADDR_BUS-1:0] branch_addr,
  output logic                rom_en,
  output logic [ADDR_BUS-1:0] rom_addr,
  input  logic                rom_ready,
  input  logic [INST_BUS-1:0] rom_rdata,
  output logic                inst_valid,
  output logic [ADDR_BUS-1:0] addr,
  output logic [INST_BUS-1:0] inst,
  output logic                stall_request
);

  // REQ: request outstanding; HAVE: word buffered for decode;
  // DRAIN: a response is still owed for an abandoned address.
  localparam logic [1:0] ST_REQ   = 2'd0;
  localparam logic [1:0] ST_HAVE  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]          state;
  logic [ADDR_BUS-1:0] pc;
  logic [ADDR_BUS-1:0] drain_addr;
  logic [INST_BUS-1:0] inst_buf;
  logic                br_pend;
  logic [ADDR_BUS-1:0] br_target;
  logic [ADDR_BUS-1:0] next_pc;

  pc_next_sel #(
    .PC_STEP(PC_STEP)
  ) u_pc_next_sel (
    .pc          (pc),
    .br_pend     (br_pend),
    .br_target   (br_target),
    .branch_flag (branch_flag),
    .branch_addr (branch_addr),
    .next_pc     (next_pc)
  );

  // Branches seen while the delay slot is still being fetched are recorded
  // and applied at handoff; stalled cycles carry stale decode operands.
  logic capture_branch;
  assign capture_branch = branch_flag && !stall;

  // State, PC and buffers; flush outranks stall and branch in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_REQ;
      pc         <= RESET_PC;
      drain_addr <= '0;
      inst_buf   <= INST_NOP;
      br_pend    <= 1'b0;
      br_target  <= '0;
    end else if (flush) begin
      // NOTE: non-blocking assignments let every register sample pre-edge values.
      pc       <= flush_pc;
      br_pend  <= 1'b0;
      inst_buf <= INST_NOP;
      case (state)
        ST_REQ: begin
          if (rom_ready) begin
            state <= ST_REQ;
          end else begin
            // Keep the abandoned address on the bus until the ROM answers.
            state      <= ST_DRAIN;
            drain_addr <= pc;
          end
        end
        // Still owing the old response; only a same-cycle ready settles it.
        ST_DRAIN: state <= rom_ready ? ST_REQ : ST_DRAIN;
        default:  state <= ST_REQ;
      endcase
    end else begin
      case (state)
        ST_REQ: begin
          if (capture_branch) begin
            br_pend   <= 1'b1;
            br_target <= branch_addr;
          end
          if (rom_ready) begin
            inst_buf <= rom_rdata;
            state    <= ST_HAVE;
          end
        end
        ST_HAVE: begin
          if (!stall) begin
            pc      <= next_pc;
            br_pend <= 1'b0;
            state   <= ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (capture_branch) begin
            br_pend   <= 1'b1;
            br_target <= branch_addr;
          end
          if (rom_ready) begin
            state <= ST_REQ;
          end
        end
        default: state <= ST_REQ;
      endcase
    end
  end

  assign rom_en        = !rst && (state != ST_HAVE);
  assign rom_addr      = (state == ST_DRAIN) ? drain_addr : pc;
  assign inst_valid    = (state == ST_HAVE);
  assign addr          = pc;
  assign inst          = inst_valid ? inst_buf : INST_NOP;
  assign stall_request = !rst && (state != ST_HAVE);

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios followed by random
// traffic, all compared against a transaction-level fetch model.
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        branch_flag;
  logic [31:0] branch_addr;
  logic        rom_en;
  logic [31:0] rom_addr;
  logic        rom_ready;
  logic [31:0] rom_rdata;
  logic        inst_valid;
  logic [31:0] addr;
  logic [31:0] inst;
  logic        stall_request;

  int tests = 0;
  int fails = 0;

  // Reference model: the address owed to decode next, whether its word has
  // arrived, a recorded redirect, and an abandoned handshake still owed.
  logic [31:0] m_pc;
  logic        m_have;
  logic        m_br_pend;
  logic [31:0] m_br_target;
  logic        m_owed;
  logic [31:0] m_drain_addr;
  logic [31:0] deliv[$];

  // ROM responder state.
  int          wait_cnt;
  int          lat;
  bit          lat_rand;
  logic [31:0] req_addr;

  if_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .branch_flag   (branch_flag),
    .branch_addr   (branch_addr),
    .rom_en        (rom_en),
    .rom_addr      (rom_addr),
    .rom_ready     (rom_ready),
    .rom_rdata     (rom_rdata),
    .inst_valid    (inst_valid),
    .addr          (addr),
    .inst          (inst),
    .stall_request (stall_request)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = RESET_PC;
    m_have    = 1'b0;
    m_br_pend = 1'b0;
    m_br_target = '0;
    m_owed    = 1'b0;
    m_drain_addr = '0;
    wait_cnt  = 0;
    deliv.delete();
  endtask

  // One clock cycle: drive inputs, answer the ROM, compare, advance the model.
  task automatic cycle(input logic st, input logic bf, input logic [31:0] ba,
                       input logic fl, input logic [31:0] fpc);
    logic rdy;
    logic en_s;
    stall       = st;
    branch_flag = bf;
    branch_addr = ba;
    flush       = fl;
    flush_pc    = fpc;
    if (rom_en && wait_cnt == 0 && lat_rand) lat = $urandom_range(0, 3);
    en_s      = rom_en;
    rdy       = rom_en && (wait_cnt >= lat);
    rom_ready = rdy;
    rom_rdata = rdy ? rom_word(rom_addr) : $urandom();

    check("rom_en", {31'b0, rom_en}, {31'b0, !m_have});
    if (!m_have) check("rom_addr", rom_addr, m_owed ? m_drain_addr : m_pc);
    if (rom_en && wait_cnt > 0) check("rom_addr_stable", rom_addr, req_addr);
    if (rom_en && wait_cnt == 0) req_addr = rom_addr;
    check("inst_valid", {31'b0, inst_valid}, {31'b0, m_have});
    check("addr", addr, m_pc);
    check("inst", inst, m_have ? rom_word(m_pc) : 32'h0);
    check("stall_request", {31'b0, stall_request}, {31'b0, !m_have});

    @(posedge clk);
    if (fl) begin
      if (!m_have && !m_owed) begin
        if (!rdy) begin
          m_owed       = 1'b1;
          m_drain_addr = m_pc;
        end
      end else if (m_owed && rdy) begin
        m_owed = 1'b0;
      end
      m_have    = 1'b0;
      m_pc      = fpc;
      m_br_pend = 1'b0;
    end else if (m_have) begin
      if (!st) begin
        deliv.push_back(m_pc);
        m_pc      = m_br_pend ? m_br_target : (bf ? ba : m_pc + 32'd4);
        m_br_pend = 1'b0;
        m_have    = 1'b0;
      end
    end else begin
      if (bf && !st) begin
        m_br_pend   = 1'b1;
        m_br_target = ba;
      end
      if (rdy) begin
        if (m_owed) m_owed = 1'b0;
        else        m_have = 1'b1;
      end
    end
    if (rdy) wait_cnt = 0;
    else if (en_s) wait_cnt++;
    @(negedge clk);
    rom_ready = 1'b0;
  endtask

  // Asynchronous reset: outputs must take reset values before any clock edge.
  task automatic do_reset();
    rst         = 1'b1;
    stall       = 1'b0;
    flush       = 1'b0;
    flush_pc    = '0;
    branch_flag = 1'b0;
    branch_addr = '0;
    rom_ready   = 1'b0;
    rom_rdata   = '0;
    #1;
    check("rst_rom_en", {31'b0, rom_en}, 32'd0);
    check("rst_stall_request", {31'b0, stall_request}, 32'd0);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_addr", addr, RESET_PC);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic run_deliv(input int target, input int budget);
    for (int i = 0; i < budget && deliv.size() < target; i++) cycle(0, 0, '0, 0, '0);
    check("deliv_count", 32'(deliv.size()), 32'(target));
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b1;
    lat = 0;
    lat_rand = 0;
    model_reset();
    @(negedge clk);

    // Zero-latency ROM, branch seen while the delay slot BFC00008 is requested.
    do_reset();
    lat = 0;
    repeat (4) cycle(0, 0, '0, 0, '0);
    cycle(0, 1, 32'hBFC0_0100, 0, '0);
    run_deliv(4, 20);
    if (deliv.size() >= 4) begin
      check("seq0", deliv[0], 32'hBFC0_0000);
      check("seq1", deliv[1], 32'hBFC0_0004);
      check("delay_slot", deliv[2], 32'hBFC0_0008);
      check("branch_target", deliv[3], 32'hBFC0_0100);
    end

    // Same branch arriving in the handoff cycle of the delay slot.
    do_reset();
    repeat (5) cycle(0, 0, '0, 0, '0);
    cycle(0, 1, 32'hBFC0_0100, 0, '0);
    run_deliv(4, 20);
    if (deliv.size() >= 4) begin
      check("ho_delay_slot", deliv[2], 32'hBFC0_0008);
      check("ho_branch_target", deliv[3], 32'hBFC0_0100);
    end

    // Three-cycle ROM latency: five cycles per instruction.
    do_reset();
    lat = 3;
    repeat (12) cycle(0, 0, '0, 0, '0);
    check("lat3_deliveries", 32'(deliv.size()), 32'd2);

    // Stall in HAVE with branch_flag held: no capture, then sequential step.
    lat = 1;
    for (int i = 0; i < 10 && !m_have; i++) cycle(0, 0, '0, 0, '0);
    a = m_pc;
    repeat (4) cycle(1, 1, $urandom(), 0, '0);
    cycle(0, 0, '0, 0, '0);
    check("stall_next_pc", rom_addr, a + 32'd4);

    // Flush mid-request after a branch was recorded: drain, then restart clean.
    do_reset();
    lat = 3;
    cycle(0, 0, '0, 0, '0);
    cycle(0, 1, 32'hBFC0_0500, 0, '0);
    cycle(0, 1, 32'hBFC0_0600, 1, 32'hBFC0_0380);
    check("drain_addr", rom_addr, RESET_PC);
    check("drain_inst_valid", {31'b0, inst_valid}, 32'd0);
    run_deliv(2, 30);
    if (deliv.size() >= 2) begin
      check("flush_target", deliv[0], 32'hBFC0_0380);
      check("flush_br_cleared", deliv[1], 32'hBFC0_0384);
    end

    // Reset asserted mid-request, then fetch restarts at the reset vector.
    cycle(0, 0, '0, 0, '0);
    do_reset();
    run_deliv(1, 20);
    if (deliv.size() >= 1) check("restart_pc", deliv[0], RESET_PC);

    // Random traffic with random ROM latency.
    lat_rand = 1;
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom(),
            $urandom_range(0, 19) == 0, $urandom());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
